// File: rtl/seg7_count_display_if.sv
// Count-in / display-out bundle for the 4-digit 7-segment driver.
// The slave side is the display block; the master side is whoever supplies
// the count and looks at the pins.
interface seg7_count_display_if;
    logic [13:0] i_count;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_an;
    logic [15:0] o_bcd;
    logic        o_overflow;
    logic        o_valid;

    modport slave (
        input  i_count,
        output o_seg, o_dp, o_an, o_bcd, o_overflow, o_valid
    );

    modport master (
        output i_count,
        input  o_seg, o_dp, o_an, o_bcd, o_overflow, o_valid
    );
endinterface

// File: rtl/seg7_count_display.sv
// Binary count to 4-digit multiplexed 7-segment display.
// A free-running sequential double-dabble converts the count to BCD every
// 16 cycles; an independent scan divider walks the four digit anodes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_LOAD   | capture i_count, clear BCD shift register and iteration count
// S_SHIFT  | 14 cycles of add-3-if->=5 then shift {bcd,bin} left by one
// S_UPDATE | publish BCD and overflow, pulse o_valid on the next cycle
module seg7_count_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    seg7_count_display_if.slave  bus
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_RST = SEG_ACTIVE_LOW ? ~7'h3F : 7'h3F;
    localparam logic [3:0] AN_RST  = AN_ACTIVE_LOW ? 4'b1110 : 4'b0001;

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_UPDATE} state_t;

    state_t           state_q, state_d;
    logic [13:0]      bin_q, bin_d;
    logic [15:0]      shf_q, shf_d;
    logic [3:0]       iter_q, iter_d;
    logic             cap_ovf_q, cap_ovf_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    logic [15:0] adj;
    logic [3:0]  nib;
    logic        blank;
    logic [6:0]  raw;
    logic [3:0]  onehot;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h00;
        endcase
    endfunction

    // Conversion FSM: next state and datapath for the double-dabble engine.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        shf_d     = shf_q;
        iter_d    = iter_q;
        cap_ovf_d = cap_ovf_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        adj       = shf_q;
        case (state_q)
            S_LOAD: begin
                bin_d     = bus.i_count;
                shf_d     = '0;
                iter_d    = '0;
                cap_ovf_d = (bus.i_count > 14'd9999);
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                for (int k = 0; k < 4; k++) begin
                    if (shf_q[4*k +: 4] >= 4'd5) begin
                        adj[4*k +: 4] = shf_q[4*k +: 4] + 4'd3;
                    end
                end
                // The ten-thousands bit falls off the top; only the overflow
                // flag remembers it.
                shf_d  = {adj[14:0], bin_q[13]};
                bin_d  = {bin_q[12:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd13) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                bcd_d   = shf_q;
                ovf_d   = cap_ovf_q;
                valid_d = 1'b1;
                state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Scan divider and registered digit decode; decoding from the next-state
    // BCD/index keeps anode and segments changing on the same edge.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end

        nib    = 4'd0;
        blank  = 1'b0;
        onehot = 4'b0001;
        case (idx_d)
            2'd0: begin nib = bcd_d[3:0];   blank = 1'b0;                  onehot = 4'b0001; end
            2'd1: begin nib = bcd_d[7:4];   blank = (bcd_d[15:4] == '0);  onehot = 4'b0010; end
            2'd2: begin nib = bcd_d[11:8];  blank = (bcd_d[15:8] == '0);  onehot = 4'b0100; end
            default: begin nib = bcd_d[15:12]; blank = (bcd_d[15:12] == '0); onehot = 4'b1000; end
        endcase

        if (ovf_d) begin
            raw = 7'h40;
        end else if (BLANK_LEADING && blank) begin
            raw = 7'h00;
        end else begin
            raw = enc(nib);
        end

        seg_d = SEG_ACTIVE_LOW ? ~raw : raw;
        an_d  = AN_ACTIVE_LOW ? ~onehot : onehot;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_LOAD;
            bin_q     <= '0;
            shf_q     <= '0;
            iter_q    <= '0;
            cap_ovf_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            div_q     <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_RST;
            an_q      <= AN_RST;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            shf_q     <= shf_d;
            iter_q    <= iter_d;
            cap_ovf_q <= cap_ovf_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus.o_bcd      = bcd_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_seg      = seg_q;
    assign bus.o_an       = an_q;
    assign bus.o_dp       = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_seg7_count_display.sv
// Scoreboard bench for seg7_count_display with SCAN_DIV=4.
module tb_seg7_count_display;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rel_cyc = 0;
    bit   lat_chk = 1'b0;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];

    seg7_count_display_if bus();

    seg7_count_display #(
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1),
        .BLANK_LEADING  (1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every o_valid pulse consumes one expected conversion result.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid actual=bcd %h required=no pulse", bus.o_bcd);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_bcd", {16'h0, bus.o_bcd}, {16'h0, e.bcd});
                chk("sb_ovf", {31'h0, bus.o_overflow}, {31'h0, e.ovf});
                if (lat_chk) begin
                    lat_chk = 1'b0;
                    chk("first_valid_latency", cyc - rel_cyc, 32'd16);
                end
            end
        end
    end

    task automatic push(input logic [15:0] b, input logic o);
        exp_t e;
        e.bcd = b;
        e.ovf = o;
        sbq.push_back(e);
    endtask

    // One full conversion period starting at the negedge before a load edge.
    task automatic run_frame(input logic [13:0] v, input logic [15:0] b, input logic o);
        bus.i_count = v;
        push(b, o);
        repeat (16) @(negedge clk);
    endtask

    task automatic check_display(input logic [6:0] e0, input logic [6:0] e1,
                                 input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] ex [4];
        int hits [4];
        int d;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        for (int i = 0; i < 4; i++) hits[i] = 0;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            d = -1;
            case (bus.o_an)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: begin
                    total++;
                    bad++;
                    $display("FAIL an_onehot actual=%b required=one-hot-low", bus.o_an);
                end
            endcase
            if (d >= 0) begin
                hits[d]++;
                chk($sformatf("seg_digit%0d", d), {25'h0, bus.o_seg}, {25'h0, ex[d]});
            end
            chk("dp_unlit", {31'h0, bus.o_dp}, 32'd1);
        end
        for (int i = 0; i < 4; i++) chk($sformatf("scan_hits%0d", i), hits[i], 32'd4);
    endtask

    // Two frames at the same value: the second one shows a stable display.
    task automatic frame_disp(input logic [13:0] v, input logic [15:0] b, input logic o,
                              input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        run_frame(v, b, o);
        bus.i_count = v;
        push(b, o);
        check_display(e0, e1, e2, e3);
    endtask

    initial begin
        bus.i_count = 14'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bcd",   {16'h0, bus.o_bcd}, 32'h0);
        chk("rst_valid", {31'h0, bus.o_valid}, 32'd0);
        chk("rst_ovf",   {31'h0, bus.o_overflow}, 32'd0);
        chk("rst_an",    {28'h0, bus.o_an}, 32'b1110);
        chk("rst_seg",   {25'h0, bus.o_seg}, 32'b1000000);

        rst_n   = 1'b1;
        rel_cyc = cyc;
        lat_chk = 1'b1;
        run_frame(14'd0, 16'h0000, 1'b0);

        frame_disp(14'd1234, 16'h1234, 1'b0,
                   7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
        frame_disp(14'd7, 16'h0007, 1'b0,
                   7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);
        frame_disp(14'd9999, 16'h9999, 1'b0,
                   7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);
        frame_disp(14'd10000, 16'h0000, 1'b1,
                   7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
        run_frame(14'd0, 16'h0000, 1'b0);
        run_frame(14'd16383, 16'h6383, 1'b1);
        frame_disp(14'd305, 16'h0305, 1'b0,
                   7'b0010010, 7'b1000000, 7'b0110000, 7'b1111111);

        // Input change while a conversion is in flight.
        bus.i_count = 14'd5;
        push(16'h0005, 1'b0);
        repeat (3) @(negedge clk);
        bus.i_count = 14'd42;
        repeat (13) @(negedge clk);
        run_frame(14'd42, 16'h0042, 1'b0);

        // Reset during S_SHIFT aborts the conversion without a pulse.
        bus.i_count = 14'd321;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_bcd",   {16'h0, bus.o_bcd}, 32'h0);
        chk("midrst_valid", {31'h0, bus.o_valid}, 32'd0);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        lat_chk = 1'b1;
        run_frame(14'd321, 16'h0321, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
